// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/datapath signal bundle for the multicycle MIPS controller
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_en;
  logic [1:0]       pc_src;
  logic             ir_write;
  logic             reg_dst;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             mem_read;
  logic             mem_write;
  logic             instr_done;
  logic             illegal;
  logic             mem_timeout;
  logic [CNT_W-1:0] retired;
  logic [3:0]       state;

  // Controller side
  modport master (
    input  run, opcode, zero, mem_ready,
    output pc_en, pc_src, ir_write, reg_dst, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, mem_read, mem_write,
           instr_done, illegal, mem_timeout, retired, state
  );

  // Datapath / environment side
  modport slave (
    output run, opcode, zero, mem_ready,
    input  pc_en, pc_src, ir_write, reg_dst, reg_write, mem_to_reg,
           alu_src_a, alu_src_b, alu_op, mem_read, mem_write,
           instr_done, illegal, mem_timeout, retired, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM sequencing a multicycle MIPS datapath
module multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_EXEC_I   = 4'd11,
    S_I_WB     = 4'd12,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Wait counter only needs to reach MEM_WAIT_MAX; it saturates when the timeout is disabled.
  localparam int                WAIT_W   = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MEM_WAIT_MAX);
  localparam bit                WAIT_EN  = (MEM_WAIT_MAX != 0);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d, wait_inc;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic       pc_en;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       reg_dst;
  logic       reg_write;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       mem_read;
  logic       mem_write;
  logic       instr_done;

  assign wait_inc = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);

  // State, sticky flags, wait counter and retirement counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      retired_q <= retired_d;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_write  = 1'b1;
        pc_en     = 1'b1;
        alu_src_b = 2'b01;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is computed speculatively here into ALUOut
        alu_src_b = 2'b11;
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_EXEC_I;
          default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        // Only path into the memory states, so the wait counter is cleared here
        wait_d    = '0;
        state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          state_d = S_MEM_WB;
        end else begin
          wait_d = wait_inc;
          if (WAIT_EN && (wait_inc == WAIT_LIM)) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          instr_done = 1'b1;
        end else begin
          wait_d = wait_inc;
          if (WAIT_EN && (wait_inc == WAIT_LIM)) begin
            state_d   = S_ERROR;
            timeout_d = 1'b1;
          end
        end
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_src     = 2'b01;
        pc_en      = bus.zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_en      = 1'b1;
        pc_src     = 2'b10;
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase

    // Instruction boundary: run is re-sampled on every retirement
    if (instr_done) state_d = bus.run ? S_FETCH : S_IDLE;
  end

  // Retirement count, wrapping naturally at 2^CNT_W
  always_comb begin
    retired_d = retired_q;
    if (instr_done) retired_d = retired_q + CNT_W'(1);
  end

  assign bus.pc_en       = pc_en;
  assign bus.pc_src      = pc_src;
  assign bus.ir_write    = ir_write;
  assign bus.reg_dst     = reg_dst;
  assign bus.reg_write   = reg_write;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_op      = alu_op;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.instr_done  = instr_done;
  assign bus.illegal     = illegal_q;
  assign bus.mem_timeout = timeout_q;
  assign bus.retired     = retired_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed vector bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus ();

  multicycle_ctrl #(.MEM_WAIT_MAX(15), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       instr_done;
    logic       illegal;
    logic       mem_timeout;
  } outs_t;

  //                          pe  src  ir  rd  rw  m2r a   srcb  op    mr  mw  dn  il  to
  localparam outs_t O_NONE   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_FETCH  = {1'b1,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_DEC    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_MADDR  = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_MRD    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_MWB    = {1'b0,2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t O_MWR    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0};
  localparam outs_t O_MWR_DN = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0};
  localparam outs_t O_EXR    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_RWB    = {1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t O_BR_T   = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t O_BR_N   = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t O_JMP    = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};
  localparam outs_t O_EXI    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0};
  localparam outs_t O_IWB    = {1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0};

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [3:0]  st;
    outs_t       o;
    int unsigned ret;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic r, logic [5:0] op, logic z, logic rd,
                              logic [3:0] st, outs_t o, int unsigned ret);
    vec_t v;
    v.run = r; v.op = op; v.zero = z; v.rdy = rd; v.st = st; v.o = o; v.ret = ret;
    tbl.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic outs_t sample_outs();
    outs_t a;
    a = {bus.pc_en, bus.pc_src, bus.ir_write, bus.reg_dst, bus.reg_write, bus.mem_to_reg,
         bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.mem_read, bus.mem_write,
         bus.instr_done, bus.illegal, bus.mem_timeout};
    return a;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    bus.mem_ready = 1'b0;
    bus.zero = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_state(string name, logic [3:0] tgt, int budget);
    int n = 0;
    while (bus.state !== tgt && n < budget) begin
      step();
      n++;
    end
    chk(name, 32'(bus.state), 32'(tgt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    logic bad;
    outs_t act;

    // R-type x3 from IDLE, retired=3 after 12 cycles past IDLE
    add(0, OP_R, 0, 0, 4'd0,  O_NONE,  0);
    add(1, OP_R, 0, 0, 4'd0,  O_NONE,  0);
    for (int k = 0; k < 3; k++) begin
      add(1, OP_R, 0, 0, 4'd1, O_FETCH, k);
      add(1, OP_R, 0, 0, 4'd2, O_DEC,   k);
      add(1, OP_R, 0, 0, 4'd7, O_EXR,   k);
      add(1, OP_R, 0, 0, 4'd8, O_RWB,   k);
    end
    // lw with 3 not-ready cycles
    add(1, OP_LW, 0, 0, 4'd1, O_FETCH, 3);
    add(1, OP_LW, 0, 0, 4'd2, O_DEC,   3);
    add(1, OP_LW, 0, 0, 4'd3, O_MADDR, 3);
    add(1, OP_LW, 0, 0, 4'd4, O_MRD,   3);
    add(1, OP_LW, 0, 0, 4'd4, O_MRD,   3);
    add(1, OP_LW, 0, 0, 4'd4, O_MRD,   3);
    add(1, OP_LW, 0, 1, 4'd4, O_MRD,   3);
    add(1, OP_LW, 0, 0, 4'd5, O_MWB,   3);
    // beq taken, then not taken
    add(1, OP_BEQ, 1, 0, 4'd1, O_FETCH, 4);
    add(1, OP_BEQ, 1, 0, 4'd2, O_DEC,   4);
    add(1, OP_BEQ, 1, 0, 4'd9, O_BR_T,  4);
    add(1, OP_BEQ, 0, 0, 4'd1, O_FETCH, 5);
    add(1, OP_BEQ, 0, 0, 4'd2, O_DEC,   5);
    add(1, OP_BEQ, 0, 0, 4'd9, O_BR_N,  5);
    // addi
    add(1, OP_ADDI, 0, 0, 4'd1,  O_FETCH, 6);
    add(1, OP_ADDI, 0, 0, 4'd2,  O_DEC,   6);
    add(1, OP_ADDI, 0, 0, 4'd11, O_EXI,   6);
    add(1, OP_ADDI, 0, 0, 4'd12, O_IWB,   6);
    // sw with one not-ready cycle
    add(1, OP_SW, 0, 0, 4'd1, O_FETCH,  7);
    add(1, OP_SW, 0, 0, 4'd2, O_DEC,    7);
    add(1, OP_SW, 0, 0, 4'd3, O_MADDR,  7);
    add(1, OP_SW, 0, 0, 4'd6, O_MWR,    7);
    add(1, OP_SW, 0, 1, 4'd6, O_MWR_DN, 7);
    // j with run dropped at the boundary
    add(1, OP_J, 0, 0, 4'd1,  O_FETCH, 8);
    add(1, OP_J, 0, 0, 4'd2,  O_DEC,   8);
    add(0, OP_J, 0, 0, 4'd10, O_JMP,   8);
    add(0, OP_J, 0, 0, 4'd0,  O_NONE,  9);
    add(0, OP_J, 0, 0, 4'd0,  O_NONE,  9);

    bus.opcode = OP_R;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    foreach (tbl[i]) begin
      bus.run = tbl[i].run;
      bus.opcode = tbl[i].op;
      bus.zero = tbl[i].zero;
      bus.mem_ready = tbl[i].rdy;
      #1;
      act = sample_outs();
      chk($sformatf("row%0d state", i), 32'(bus.state), 32'(tbl[i].st));
      chk($sformatf("row%0d outs", i), 32'(act), 32'(tbl[i].o));
      chk($sformatf("row%0d retired", i), bus.retired, tbl[i].ret);
      step();
    end

    // Reset mid-instruction discards the lw and clears retired
    bus.run = 1'b1;
    bus.opcode = OP_LW;
    bus.mem_ready = 1'b0;
    wait_state("midrst reach MEM_RD", 4'd4, 10);
    rst = 1'b1;
    step();
    chk("midrst state", 32'(bus.state), 32'd0);
    chk("midrst retired", bus.retired, 32'd0);
    rst = 1'b0;

    // sw timeout after 15 not-ready cycles
    do_reset();
    bus.run = 1'b1;
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b0;
    wait_state("to reach MEM_WR", 4'd6, 10);
    n = 0;
    while (bus.state === 4'd6 && n < 40) begin
      n++;
      step();
    end
    chk("to wait cycles", 32'(n), 32'd15);
    chk("to state", 32'(bus.state), 32'd15);
    chk("to mem_timeout", 32'(bus.mem_timeout), 32'd1);
    chk("to illegal", 32'(bus.illegal), 32'd0);
    repeat (3) step();
    chk("to sticky state", 32'(bus.state), 32'd15);
    chk("to sticky flag", 32'(bus.mem_timeout), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to rst state", 32'(bus.state), 32'd0);
    chk("to rst flag", 32'(bus.mem_timeout), 32'd0);

    // Ready on the cycle the counter would hit the limit wins
    bus.run = 1'b1;
    bus.opcode = OP_SW;
    bus.mem_ready = 1'b0;
    wait_state("tie reach MEM_WR", 4'd6, 10);
    repeat (14) step();
    chk("tie still MEM_WR", 32'(bus.state), 32'd6);
    bus.mem_ready = 1'b1;
    #1;
    chk("tie instr_done", 32'(bus.instr_done), 32'd1);
    step();
    bus.mem_ready = 1'b0;
    chk("tie next state", 32'(bus.state), 32'd1);
    chk("tie retired", bus.retired, 32'd1);
    chk("tie no timeout", 32'(bus.mem_timeout), 32'd0);

    // Illegal opcode: ERROR, no write strobes ever
    do_reset();
    bus.run = 1'b1;
    bus.opcode = OP_BAD;
    bad = 1'b0;
    n = 0;
    while (bus.state !== 4'd15 && n < 10) begin
      if (bus.reg_write || bus.mem_write) bad = 1'b1;
      step();
      n++;
    end
    chk("ill state", 32'(bus.state), 32'd15);
    chk("ill flag", 32'(bus.illegal), 32'd1);
    chk("ill no timeout", 32'(bus.mem_timeout), 32'd0);
    repeat (3) begin
      if (bus.reg_write || bus.mem_write) bad = 1'b1;
      step();
    end
    chk("ill stays", 32'(bus.state), 32'd15);
    chk("ill no writes", 32'(bad), 32'd0);
    chk("ill retired", bus.retired, 32'd0);
    do_reset();
    chk("ill rst flag", 32'(bus.illegal), 32'd0);
    chk("ill rst state", 32'(bus.state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore FSM that sequences the single-datapath MIPS core (PC, instruction register, register file, ALU, data memory) in multicycle fashion. It drives the datapath mux selects, write enables and ALU op from state, decoded from the 6-bit opcode. It adds data-memory ready handshaking with timeout, run/stop control and a retired-instruction counter. The PC is word-addressed (+1 per instruction).

Parameters:
MEM_WAIT_MAX, 15, consecutive not-ready cycles tolerated in a memory state before ERROR; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
run  in  1  start/continue execution; sampled in IDLE and at instruction boundaries
opcode  in  6  instruction bits [31:26] from the instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  data memory completes the current read/write this cycle
pc_en  out  1  PC write enable
pc_src  out  2  00 ALU result (PC+1), 01 ALUOut (branch target), 10 jump target
ir_write  out  1  instruction register load
reg_dst  out  1  0 rt, 1 rd
reg_write  out  1  register file write enable
mem_to_reg  out  1  write-back source: 0 ALUOut, 1 memory data
alu_src_a  out  1  0 PC, 1 ReadData1
alu_src_b  out  2  00 ReadData2, 01 constant 1, 10 sign-extended imm, 11 sign-extended imm (branch offset)
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
mem_read  out  1  data memory read request
mem_write  out  1  data memory write request
instr_done  out  1  one-cycle pulse on retirement
illegal  out  1  sticky: unsupported opcode decoded
mem_timeout  out  1  sticky: memory handshake timed out
retired  out  CNT_W  count of retired instructions, wraps modulo 2^CNT_W
state  out  4  current state encoding

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, retired=0, illegal=0, mem_timeout=0, wait counter=0. All outputs are 0 in IDLE. Reset has priority mid-instruction and discards any in-flight instruction.
- States and encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, EXEC_R 7, R_WB 8, BRANCH 9, JUMP 10, EXEC_I 11, I_WB 12, ERROR 15.
- Outputs are a pure decode of state (plus zero and mem_ready where noted). Any signal not listed for a state is 0.
- IDLE: next state is FETCH if run=1, else IDLE.
- FETCH: ir_write=1, pc_en=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=00. Next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, which precomputes the branch target. Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> EXEC_I
  - any other opcode -> ERROR, with illegal set to 1.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, held until mem_ready=1, then MEM_WB.
- MEM_WR: mem_write=1, held until mem_ready=1. On that cycle instr_done=1 and the FSM takes the boundary transition.
- Wait counter in MEM_RD/MEM_WR:
  - cleared on entry to the state;
  - increments on each cycle with mem_ready=0;
  - if MEM_WAIT_MAX≠0 and the counter reaches MEM_WAIT_MAX, next state is ERROR and mem_timeout is set to 1;
  - mem_ready=1 always wins over the timeout on the same cycle.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10. Next state is R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero, instr_done=1.
- JUMP: pc_en=1, pc_src=10, instr_done=1.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is I_WB.
- I_WB: reg_write=1, reg_dst=0, instr_done=1.
- Boundary transition, taken on every instr_done cycle: next state is FETCH if run=1, else IDLE. retired increments by 1 on the same edge.
- ERROR: all strobes are 0. The FSM stays in ERROR until rst. illegal and mem_timeout hold their values.
- Latency in cycles from FETCH to retirement, inclusive: R-type 4, addi 4, beq 3, j 3, sw 4+w, lw 5+w. w is the number of not-ready cycles.

Test Plan:
- Reset, then run=1 with opcode=000000 constant: state sequence 0,1,2,7,8,1,...; instr_done on R_WB cycles. retired=3 after 12 cycles past IDLE exit.
- lw (100011) with mem_ready low for 3 cycles: mem_read high 4 cycles, then MEM_WB with reg_write=1, mem_to_reg=1. Total 8 cycles, retired+1.
- beq (000100): zero=1 gives pc_en=1, pc_src=01 in BRANCH. zero=0 gives pc_en=0. 3 cycles each.
- sw with mem_ready held 0 and MEM_WAIT_MAX=15: after 15 not-ready cycles, state=15 and mem_timeout=1. Stays put despite run=1; rst returns state=0 with all flags 0.
- Opcode 111111 decoded: ERROR with illegal=1, no reg_write/mem_write ever asserted. run=0 at a j boundary gives state=IDLE after JUMP.
